// File: rtl/vga_pix_unpack_pkg.sv
// Shared types and frame constants for the VGA pixel source and display timing stage.
package vga_pix_unpack_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int PIX_W       = 8;
    localparam int WORD_W      = 32;
    localparam int LANES       = WORD_W / PIX_W;
    localparam int H_ACTIVE    = 1280;
    localparam int V_ACTIVE    = 768;
    localparam int FRAME_WORDS = H_ACTIVE * V_ACTIVE / LANES;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/vga_word_fifo.sv
// Single-clock show-ahead word FIFO with occupancy count and synchronous flush.
module vga_word_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 32
) (
    input  logic                   vga_clk,
    input  logic                   rstn,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // Storage array; contents need no reset because empty gates every read.
    always_ff @(posedge vga_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); flush empties the buffer.
    always_ff @(posedge vga_clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_pix_unpack.sv
// Word-to-pixel unpacker feeding the VGA timing stage: per-frame word budget,
// low-watermark read pacing, byte-lane serialisation and error flags.
//
// state | meaning
// IDLE  | no frame armed, inputs ignored
// FILL  | frame armed, words_left > 0, accepting words
// DRAIN | budget fetched, emptying the remaining buffered pixels
module vga_pix_unpack
    import vga_pix_unpack_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int LOW_WM      = 8,
    parameter int FRAME_WORDS = vga_pix_unpack_pkg::FRAME_WORDS,
    parameter int CNT_W       = 18
) (
    input  logic        vga_clk,
    input  logic        rstn,
    input  logic        frame_start,
    output logic        word_req,
    input  logic        word_valid,
    input  logic [31:0] word_data,
    output logic        word_ready,
    input  logic        rfifo_req,
    output logic [7:0]  rfifo_data,
    output logic        FIFO_EMPTY,
    output logic        frame_done,
    output logic        overflow,
    output logic [15:0] underflow_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  words_left;
    logic [1:0]        lane;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    logic              full;
    logic              empty;
    logic [WORD_W-1:0] head_word;
    logic              push;
    logic              pix_pop;
    logic              word_pop;
    logic              word_req_c;
    logic              frame_done_c;

    // frame_start wins over any push or pop in the same cycle.
    assign push       = word_valid && !full && (state == FILL) && !frame_start;
    assign pix_pop    = rfifo_req && !empty && !frame_start;
    assign word_pop   = pix_pop && (lane == 2'd3);
    assign word_ready = !full;
    assign FIFO_EMPTY = empty;
    assign rfifo_data = empty ? '0 : head_word[{lane, 3'b000} +: PIX_W];

    vga_word_fifo #(
        .DEPTH (DEPTH),
        .W     (WORD_W)
    ) u_fifo (
        .vga_clk (vga_clk),
        .rstn    (rstn),
        .flush   (frame_start),
        .push    (push),
        .wdata   (word_data),
        .pop     (word_pop),
        .rdata   (head_word),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // Occupancy after this cycle, used so pacing and drain detection see the upcoming value.
    always_comb begin
        count_nxt = count;
        case ({push, word_pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // State register.
    always_ff @(posedge vga_clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        if (frame_start) begin
            state_nxt = FILL;
        end else begin
            case (state)
                FILL:    if (push && words_left == CNT_W'(1)) state_nxt = DRAIN;
                DRAIN:   if (count_nxt == '0) state_nxt = IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    // Output decode; word_req is held low for the frame_start cycle so DDR sees a clean restart.
    always_comb begin
        word_req_c   = !frame_start && (state_nxt == FILL) && (count_nxt <= CW'(LOW_WM));
        frame_done_c = !frame_start && (state == DRAIN) && (state_nxt == IDLE);
    end

    // Registered outputs, frame budget, byte lane and error flags.
    always_ff @(posedge vga_clk or negedge rstn) begin
        if (!rstn) begin
            word_req      <= 1'b0;
            frame_done    <= 1'b0;
            overflow      <= 1'b0;
            underflow_cnt <= '0;
            words_left    <= '0;
            lane          <= '0;
        end else begin
            word_req   <= word_req_c;
            frame_done <= frame_done_c;
            if (frame_start) begin
                overflow      <= 1'b0;
                underflow_cnt <= '0;
                words_left    <= CNT_W'(FRAME_WORDS);
                lane          <= '0;
            end else begin
                if (word_valid && full && state == FILL) begin
                    overflow <= 1'b1;
                end
                if (rfifo_req && empty) begin
                    underflow_cnt <= sat_inc16(underflow_cnt);
                end
                if (push && words_left != '0) begin
                    words_left <= words_left - 1'b1;
                end
                if (pix_pop) begin
                    lane <= lane + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_pix_unpack.sv
// Scoreboard bench for vga_pix_unpack: directed stimulus pushes expected pixels
// into a queue, a negedge monitor pops and compares on every real pixel pop.
`timescale 1ns/1ps
module tb_vga_pix_unpack;
    import vga_pix_unpack_pkg::*;

    localparam int DEPTH  = 4;
    localparam int LOW_WM = 2;
    localparam int FW     = 8;
    localparam int CNT_W  = 18;

    logic        vga_clk     = 1'b0;
    logic        rstn        = 1'b1;
    logic        frame_start = 1'b0;
    logic        word_valid  = 1'b0;
    logic [31:0] word_data   = '0;
    logic        rfifo_req   = 1'b0;
    logic        word_req;
    logic        word_ready;
    logic [7:0]  rfifo_data;
    logic        FIFO_EMPTY;
    logic        frame_done;
    logic        overflow;
    logic [15:0] underflow_cnt;

    int          errors     = 0;
    int          checks     = 0;
    int          pix_popped = 0;
    logic [7:0]  exp_q[$];

    always #5 vga_clk = ~vga_clk;

    vga_pix_unpack #(
        .DEPTH       (DEPTH),
        .LOW_WM      (LOW_WM),
        .FRAME_WORDS (FW),
        .CNT_W       (CNT_W)
    ) dut (
        .vga_clk       (vga_clk),
        .rstn          (rstn),
        .frame_start   (frame_start),
        .word_req      (word_req),
        .word_valid    (word_valid),
        .word_data     (word_data),
        .word_ready    (word_ready),
        .rfifo_req     (rfifo_req),
        .rfifo_data    (rfifo_data),
        .FIFO_EMPTY    (FIFO_EMPTY),
        .frame_done    (frame_done),
        .overflow      (overflow),
        .underflow_cnt (underflow_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d, input bit accepted);
        word_valid = 1'b1;
        word_data  = d;
        if (accepted) begin
            for (int b = 0; b < 4; b++) exp_q.push_back(d[8*b +: 8]);
        end
        tick();
        word_valid = 1'b0;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        exp_q.delete();
        pix_popped = 0;
    endtask

    // Monitor: every accepted pixel pop is checked against the scoreboard head.
    always @(negedge vga_clk) begin
        if (rstn && rfifo_req && !FIFO_EMPTY && !frame_start) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pix_unexpected: got %0h expected none", rfifo_data);
            end else begin
                chk("pix", 32'(rfifo_data), 32'(exp_q.pop_front()));
            end
            pix_popped++;
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int  fd;
        bit  done;
        int  sent;

        // 1. reset values, then reset in the middle of a fill
        #2 rstn = 1'b0;
        tick();
        tick();
        chk("rst_word_req",   32'(word_req), 32'd0);
        chk("rst_word_ready", 32'(word_ready), 32'd1);
        chk("rst_empty",      32'(FIFO_EMPTY), 32'd1);
        chk("rst_data",       32'(rfifo_data), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_overflow",   32'(overflow), 32'd0);
        chk("rst_underflow",  32'(underflow_cnt), 32'd0);
        rstn = 1'b1;
        tick();
        chk("idle_word_req", 32'(word_req), 32'd0);
        start_frame();
        chk("wreq_fs_cycle", 32'(word_req), 32'd0);
        tick();
        chk("wreq_resume", 32'(word_req), 32'd1);
        push_word(32'hA4A3A2A1, 1'b1);
        push_word(32'hB4B3B2B1, 1'b1);
        chk("mid_count", 32'(dut.u_fifo.count), 32'd2);
        #2 rstn = 1'b0;
        #1;
        exp_q.delete();
        chk("async_empty",    32'(FIFO_EMPTY), 32'd1);
        chk("async_word_req", 32'(word_req), 32'd0);
        chk("async_count",    32'(dut.u_fifo.count), 32'd0);
        chk("async_state",    32'(dut.state), 32'(IDLE));
        chk("async_wleft",    32'(dut.words_left), 32'd0);
        tick();
        rstn = 1'b1;
        repeat (3) tick();
        chk("post_rst_word_req", 32'(word_req), 32'd0);

        // 2. two words, eight pixels in display order
        start_frame();
        push_word(32'h44332211, 1'b1);
        push_word(32'h88776655, 1'b1);
        rfifo_req = 1'b1;
        repeat (8) tick();
        rfifo_req = 1'b0;
        chk("run_empty",   32'(FIFO_EMPTY), 32'd1);
        chk("run_data0",   32'(rfifo_data), 32'd0);
        chk("run_popped",  32'(pix_popped), 32'd8);
        chk("run_q_left",  32'(exp_q.size()), 32'd0);
        chk("run_wleft",   32'(dut.words_left), 32'd6);

        // 3. full frame with continuous pops
        start_frame();
        fd   = 0;
        done = 1'b0;
        sent = 0;
        rfifo_req = 1'b1;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            if (word_req && sent < FW) begin
                word_valid = 1'b1;
                word_data  = {8'(4*sent+4), 8'(4*sent+3), 8'(4*sent+2), 8'(4*sent+1)};
                for (int b = 0; b < 4; b++) exp_q.push_back(8'(4*sent+b+1));
                sent++;
            end else begin
                word_valid = 1'b0;
            end
            tick();
            if (sent == FW && word_valid) begin
                chk("full_wreq_drop", 32'(word_req), 32'd0);
                chk("full_drain",     32'(dut.state), 32'(DRAIN));
            end
            if (frame_done) begin
                fd++;
                done = 1'b1;
                chk("fd_empty",  32'(FIFO_EMPTY), 32'd1);
                chk("fd_popped", 32'(pix_popped), 32'd32);
            end
        end
        word_valid = 1'b0;
        repeat (5) begin
            tick();
            if (frame_done) fd++;
        end
        rfifo_req = 1'b0;
        chk("fd_pulses", 32'(fd), 32'd1);
        chk("fd_idle",   32'(dut.state), 32'(IDLE));
        chk("fd_q_left", 32'(exp_q.size()), 32'd0);

        // 4. overflow
        start_frame();
        push_word(32'h03020100, 1'b1);
        push_word(32'h07060504, 1'b1);
        push_word(32'h0B0A0908, 1'b1);
        push_word(32'h0F0E0D0C, 1'b1);
        push_word(32'hDEADBEEF, 1'b0);
        chk("ovf_flag",  32'(overflow), 32'd1);
        chk("ovf_count", 32'(dut.u_fifo.count), 32'd4);
        chk("ovf_ready", 32'(word_ready), 32'd0);
        chk("ovf_wleft", 32'(dut.words_left), 32'd4);
        start_frame();
        chk("ovf_clear",       32'(overflow), 32'd0);
        chk("ovf_clear_count", 32'(dut.u_fifo.count), 32'd0);

        // 5. underflow in FILL with empty buffer
        rfifo_req = 1'b1;
        repeat (3) tick();
        rfifo_req = 1'b0;
        chk("udf_cnt",   32'(underflow_cnt), 32'd3);
        chk("udf_rdptr", 32'(dut.u_fifo.rd_ptr), 32'd0);
        chk("udf_wrptr", 32'(dut.u_fifo.wr_ptr), 32'd0);
        chk("udf_lane",  32'(dut.lane), 32'd0);
        chk("udf_data",  32'(rfifo_data), 32'd0);

        // 6a. push together with the lane-3 word pop
        push_word(32'h04030201, 1'b1);
        rfifo_req = 1'b1;
        repeat (3) tick();
        chk("col_lane3", 32'(dut.lane), 32'd3);
        push_word(32'h08070605, 1'b1);
        rfifo_req = 1'b0;
        chk("col_count", 32'(dut.u_fifo.count), 32'd1);
        chk("col_rdptr", 32'(dut.u_fifo.rd_ptr), 32'd1);
        chk("col_wrptr", 32'(dut.u_fifo.wr_ptr), 32'd2);
        rfifo_req = 1'b1;
        repeat (4) tick();
        rfifo_req = 1'b0;
        chk("col_empty", 32'(FIFO_EMPTY), 32'd1);
        chk("col_q_left", 32'(exp_q.size()), 32'd0);

        // 6b. frame_start together with push and pop
        push_word(32'h0C0B0A09, 1'b0);
        word_valid = 1'b1;
        word_data  = 32'h11111111;
        rfifo_req  = 1'b1;
        start_frame();
        word_valid = 1'b0;
        rfifo_req  = 1'b0;
        chk("fs_col_empty", 32'(FIFO_EMPTY), 32'd1);
        chk("fs_col_count", 32'(dut.u_fifo.count), 32'd0);
        chk("fs_col_wleft", 32'(dut.words_left), 32'(FW));
        chk("fs_col_lane",  32'(dut.lane), 32'd0);
        chk("fs_col_wrptr", 32'(dut.u_fifo.wr_ptr), 32'd0);
        chk("fs_col_state", 32'(dut.state), 32'(FILL));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
